// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding and the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard controller's performance counters.
// The count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble/flush generator for a 5-stage pipeline: load-use interlock,
// taken-branch flush resolved in MEM, and a full freeze while data memory is busy.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALLS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             ex_mem_stall,
  output logic             ex_mem_bubble,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [2:0] LU_RELOAD = 3'(LU_STALLS - 1);

  state_t     state;
  state_t     saved_state;
  state_t     eff_state;
  logic [2:0] lu_cnt;
  logic       lu_hit;

  assign lu_hit = ex_mem_read && (ex_rt != REG_ZERO) &&
                  ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

  // On leaving a memory freeze the pipe behaves as the state that was interrupted.
  assign eff_state = (state == MEM_WAIT) ? saved_state : state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      saved_state <= RUN;
      lu_cnt      <= '0;
    end else if (!dmem_ready) begin
      if (state != MEM_WAIT) saved_state <= state;
      state <= MEM_WAIT;
    end else if (mem_branch_taken) begin
      state  <= RUN;
      lu_cnt <= '0;
    end else if (eff_state == LU_HOLD) begin
      lu_cnt <= lu_cnt - 3'd1;
      state  <= (lu_cnt == 3'd1) ? RUN : LU_HOLD;
    end else if (lu_hit && (LU_STALLS > 1)) begin
      lu_cnt <= LU_RELOAD;
      state  <= LU_HOLD;
    end else begin
      state <= RUN;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_stall  = 1'b0;
    ex_mem_bubble = 1'b0;
    if (reset) begin
      pc_write      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (!dmem_ready) begin
      pc_write     = 1'b0;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (mem_branch_taken) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if ((eff_state == LU_HOLD) || lu_hit) begin
      pc_write     = 1'b0;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  assign state_out = state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (~pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (dmem_ready & mem_branch_taken),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: one instance with a single load-use
// bubble and 16-bit counters, one with three bubbles and 3-bit counters.
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] RUNP   = 7'b1000000;
  localparam logic [6:0] LU     = 7'b0100100;
  localparam logic [6:0] FLUSH  = 7'b1010101;
  localparam logic [6:0] FREEZE = 7'b0101010;
  localparam logic [6:0] RST    = 7'b0010101;

  logic clock = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, ex_mem_read, mem_branch_taken, dmem_ready;

  logic pc1, ifs1, iff1, ies1, ieb1, ems1, emb1;
  logic pc3, ifs3, iff3, ies3, ieb3, ems3, emb3;
  logic [1:0] state1, state3;
  logic [15:0] stall1, flush1;
  logic [2:0] stall3, flush3;
  logic [6:0] ctl1, ctl3;

  int vectors = 0;
  int miscompares = 0;

  assign ctl1 = {pc1, ifs1, iff1, ies1, ieb1, ems1, emb1};
  assign ctl3 = {pc3, ifs3, iff3, ies3, ieb3, ems3, emb3};

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.LU_STALLS(1), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken), .dmem_ready(dmem_ready),
    .pc_write(pc1), .if_id_stall(ifs1), .if_id_flush(iff1), .id_ex_stall(ies1),
    .id_ex_bubble(ieb1), .ex_mem_stall(ems1), .ex_mem_bubble(emb1),
    .state_out(state1), .stall_cycles(stall1), .flush_events(flush1)
  );

  pipeline_hazard_ctrl #(.LU_STALLS(3), .CNT_W(3)) dut3 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken), .dmem_ready(dmem_ready),
    .pc_write(pc3), .if_id_stall(ifs3), .if_id_flush(iff3), .id_ex_stall(ies3),
    .id_ex_bubble(ieb3), .ex_mem_stall(ems3), .ex_mem_bubble(emb3),
    .state_out(state3), .stall_cycles(stall3), .flush_events(flush3)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; mem_branch_taken = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic hazard_rs5();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    settle();
    vectors++; if (ctl1 !== RST) begin miscompares++; $display("FAIL reset_ctl1: got %b want %b", ctl1, RST); end
    vectors++; if (ctl3 !== RST) begin miscompares++; $display("FAIL reset_ctl3: got %b want %b", ctl3, RST); end
    tick();
    tick();
    vectors++; if (state1 !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state1); end
    vectors++; if (stall1 !== 16'd0 || flush1 !== 16'd0) begin miscompares++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall1, flush1); end
    reset = 1'b0;
    settle();
    vectors++; if (ctl1 !== RUNP) begin miscompares++; $display("FAIL reset_release: got %b want %b", ctl1, RUNP); end
  endtask

  task automatic test_load_use_single();
    do_reset();
    tick();
    hazard_rs5();
    settle();
    vectors++; if (ctl1 !== LU) begin miscompares++; $display("FAIL lu1_stall: got %b want %b", ctl1, LU); end
    tick();
    ex_mem_read = 1'b0;
    settle();
    vectors++; if (ctl1 !== RUNP) begin miscompares++; $display("FAIL lu1_resume: got %b want %b", ctl1, RUNP); end
    vectors++; if (state1 !== 2'd0) begin miscompares++; $display("FAIL lu1_state: got %0d want 0", state1); end
    vectors++; if (stall1 !== 16'd1) begin miscompares++; $display("FAIL lu1_stall_cycles: got %0d want 1", stall1); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    settle();
    vectors++; if (ctl1 !== RUNP) begin miscompares++; $display("FAIL nohaz_rt0: got %b want %b", ctl1, RUNP); end
    tick();
    ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0; id_rt = 5'd3; id_uses_rt = 1'b1;
    settle();
    vectors++; if (ctl1 !== RUNP) begin miscompares++; $display("FAIL nohaz_unused_rs: got %b want %b", ctl1, RUNP); end
    tick();
    id_rt = 5'd5;
    settle();
    vectors++; if (ctl1 !== LU) begin miscompares++; $display("FAIL haz_rt: got %b want %b", ctl1, LU); end
    tick();
    idle();
    settle();
    vectors++; if (stall1 !== 16'd1) begin miscompares++; $display("FAIL nohaz_stall_cycles: got %0d want 1", stall1); end
  endtask

  task automatic test_load_use_multi();
    logic [1:0] exp_state [3];
    exp_state[0] = 2'd1; exp_state[1] = 2'd1; exp_state[2] = 2'd0;
    do_reset();
    hazard_rs5();
    for (int i = 0; i < 3; i++) begin
      settle();
      vectors++; if (ctl3 !== LU) begin miscompares++; $display("FAIL lu3_stall%0d: got %b want %b", i, ctl3, LU); end
      tick();
      ex_mem_read = 1'b0;
      vectors++; if (state3 !== exp_state[i]) begin miscompares++; $display("FAIL lu3_state%0d: got %0d want %0d", i, state3, exp_state[i]); end
    end
    settle();
    vectors++; if (ctl3 !== RUNP) begin miscompares++; $display("FAIL lu3_resume: got %b want %b", ctl3, RUNP); end
    vectors++; if (stall3 !== 3'd3) begin miscompares++; $display("FAIL lu3_stall_cycles: got %0d want 3", stall3); end
  endtask

  task automatic test_branch_in_hold();
    do_reset();
    hazard_rs5();
    tick();
    ex_mem_read = 1'b0;
    mem_branch_taken = 1'b1;
    settle();
    vectors++; if (ctl3 !== FLUSH) begin miscompares++; $display("FAIL br_flush: got %b want %b", ctl3, FLUSH); end
    tick();
    mem_branch_taken = 1'b0;
    settle();
    vectors++; if (state3 !== 2'd0) begin miscompares++; $display("FAIL br_state: got %0d want 0", state3); end
    vectors++; if (ctl3 !== RUNP) begin miscompares++; $display("FAIL br_resume: got %b want %b", ctl3, RUNP); end
    vectors++; if (flush3 !== 3'd1 || stall3 !== 3'd1) begin miscompares++; $display("FAIL br_counters: got %0d/%0d want 1/1", flush3, stall3); end
  endtask

  task automatic test_mem_wait_branch();
    do_reset();
    hazard_rs5();
    tick();
    ex_mem_read = 1'b0;
    mem_branch_taken = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      vectors++; if (ctl3 !== FREEZE) begin miscompares++; $display("FAIL mw_freeze%0d: got %b want %b", i, ctl3, FREEZE); end
      tick();
    end
    vectors++; if (state3 !== 2'd2) begin miscompares++; $display("FAIL mw_state: got %0d want 2", state3); end
    dmem_ready = 1'b1;
    settle();
    vectors++; if (ctl3 !== FLUSH) begin miscompares++; $display("FAIL mw_flush: got %b want %b", ctl3, FLUSH); end
    tick();
    mem_branch_taken = 1'b0;
    settle();
    vectors++; if (state3 !== 2'd0 || ctl3 !== RUNP) begin miscompares++; $display("FAIL mw_resume: got state %0d ctl %b want 0 %b", state3, ctl3, RUNP); end
    vectors++; if (stall3 !== 3'd5 || flush3 !== 3'd1) begin miscompares++; $display("FAIL mw_counters: got %0d/%0d want 5/1", stall3, flush3); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    hazard_rs5();
    dmem_ready = 1'b0;
    settle();
    vectors++; if (ctl1 !== FREEZE) begin miscompares++; $display("FAIL b2b_freeze: got %b want %b", ctl1, FREEZE); end
    tick();
    dmem_ready = 1'b1;
    settle();
    vectors++; if (ctl1 !== LU) begin miscompares++; $display("FAIL b2b_lu_after_wait: got %b want %b", ctl1, LU); end
    tick();
    vectors++; if (state1 !== 2'd0) begin miscompares++; $display("FAIL b2b_state: got %0d want 0", state1); end
    settle();
    vectors++; if (ctl1 !== LU) begin miscompares++; $display("FAIL b2b_second_lu: got %b want %b", ctl1, LU); end
    tick();
    idle();
    settle();
    vectors++; if (stall1 !== 16'd3) begin miscompares++; $display("FAIL b2b_stall_cycles: got %0d want 3", stall1); end
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_ready = 1'b0;
    repeat (10) tick();
    vectors++; if (stall3 !== 3'd7) begin miscompares++; $display("FAIL sat_stall3: got %0d want 7", stall3); end
    vectors++; if (stall1 !== 16'd10) begin miscompares++; $display("FAIL sat_stall1: got %0d want 10", stall1); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    dmem_ready = 1'b0;
    tick();
    tick();
    vectors++; if (state3 !== 2'd2) begin miscompares++; $display("FAIL rmw_in_wait: got %0d want 2", state3); end
    reset = 1'b1;
    settle();
    vectors++; if (ctl3 !== RST) begin miscompares++; $display("FAIL rmw_ctl: got %b want %b", ctl3, RST); end
    tick();
    vectors++; if (state3 !== 2'd0 || stall3 !== 3'd0 || flush3 !== 3'd0) begin miscompares++; $display("FAIL rmw_cleared: got state %0d cnt %0d/%0d want 0 0/0", state3, stall3, flush3); end
    settle();
    vectors++; if (ctl3 !== RST) begin miscompares++; $display("FAIL rmw_ctl_held: got %b want %b", ctl3, RST); end
    reset = 1'b0;
    dmem_ready = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    test_reset();
    test_load_use_single();
    test_no_hazard();
    test_load_use_multi();
    test_branch_in_hold();
    test_mem_wait_branch();
    test_back_to_back();
    test_saturation();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
